// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a valid-only raster pixel stream.
// One half-row buffer of horizontal maxima plus a pair register; odd trailing column/row ignored.
module maxpool_2x2_stream #(
  parameter int IN_W   = 3,
  parameter int IN_H   = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_valid,
  output logic [DATA_W-1:0] pool_out,
  output logic              pool_valid,
  output logic              frame_done
);
  localparam int  HW    = IN_W / 2;
  localparam int  CW    = $clog2(IN_W);
  localparam int  RW    = $clog2(IN_H);
  localparam int  BW    = (HW > 1) ? $clog2(HW) : 1;
  localparam bit  ODD_W = (IN_W % 2) == 1;
  localparam bit  ODD_H = (IN_H % 2) == 1;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] pair_q;
  logic [DATA_W-1:0] rowbuf_q [HW];
  logic [DATA_W-1:0] pool_out_q;
  logic              pool_valid_q, frame_done_q;

  logic              col_last, row_last, active, hwrite, blk_done;
  logic [BW-1:0]     idx;
  logic [DATA_W-1:0] hmax, pool_d;

  assign col_last = col_q == CW'(IN_W - 1);
  assign row_last = row_q == RW'(IN_H - 1);
  // The trailing column/row exists only for odd dimensions and is count-only.
  assign active   = !(ODD_W && col_last) && !(ODD_H && row_last);
  assign idx      = BW'(col_q >> 1);
  assign hmax     = (pair_q > in_pixel) ? pair_q : in_pixel;
  assign pool_d   = (rowbuf_q[idx] > hmax) ? rowbuf_q[idx] : hmax;
  assign hwrite   = in_valid && active && col_q[0] && !row_q[0];
  assign blk_done = in_valid && active && col_q[0] && row_q[0];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pool_valid_q <= blk_done;
      frame_done_q <= in_valid && col_last && row_last;
      if (blk_done) pool_out_q <= pool_d;
    end
  end

  // Data storage is always written before it is read within a frame, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && active && !col_q[0]) pair_q <= in_pixel;
    if (!rst && hwrite) rowbuf_q[idx] <= hmax;
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench: per-cycle vector table on a 4x4 instance, plus a hand sequence on a 3x3 instance.
module tb_maxpool_2x2_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] pix4, pix3, out4, out3;
  logic       vld4, vld3, pv4, pv3, fd4, fd3;

  maxpool_2x2_stream #(.IN_W(4), .IN_H(4), .DATA_W(8)) u4 (
    .clk(clk), .rst(rst), .in_pixel(pix4), .in_valid(vld4),
    .pool_out(out4), .pool_valid(pv4), .frame_done(fd4));

  maxpool_2x2_stream u3 (
    .clk(clk), .rst(rst), .in_pixel(pix3), .in_valid(vld3),
    .pool_out(out3), .pool_valid(pv3), .frame_done(fd3));

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] p;
    logic       ev;
    logic [7:0] eo;
    logic       ed;
  } vec_t;
  typedef logic [7:0] frame_t [16];
  typedef logic [7:0] res_t   [4];

  vec_t       tbl[$];
  logic [7:0] held;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0d, required %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] p,
                     input logic ev, input logic [7:0] eo, input logic ed);
    vec_t t;
    t.r = r; t.v = v; t.p = p; t.ev = ev; t.eo = eo; t.ed = ed;
    tbl.push_back(t);
  endtask

  // Block-completing raster indices in a 4x4 frame are 5, 7, 13, 15.
  task automatic add_frame(input frame_t px, input res_t ex, input bit gaps);
    int  k = 0;
    bit  blk;
    for (int i = 0; i < 16; i++) begin
      if (gaps && i > 0)
        repeat ($urandom_range(1, 3)) add(1'b0, 1'b0, 8'h5A, 1'b0, held, 1'b0);
      blk = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      if (blk) begin
        held = ex[k];
        k++;
      end
      add(1'b0, 1'b1, px[i], blk, held, i == 15);
    end
  endtask

  frame_t asc, desc, ext;
  res_t   asc_r, desc_r, ext_r;
  int     pulses;

  initial begin
    rst = 1'b1; vld4 = 1'b0; pix4 = '0; vld3 = 1'b0; pix3 = '0; held = '0;
    for (int i = 0; i < 16; i++) begin
      asc[i]  = 8'(i + 1);
      desc[i] = 8'(16 - i);
    end
    ext    = '{8'd255, 8'd255, 8'd0, 8'd0,
               8'd255, 8'd255, 8'd0, 8'd0,
               8'd7,   8'd7,   8'd128, 8'd127,
               8'd3,   8'd7,   8'd1,   8'd2};
    asc_r  = '{8'd6, 8'd8, 8'd14, 8'd16};
    desc_r = '{8'd16, 8'd14, 8'd8, 8'd6};
    ext_r  = '{8'd255, 8'd0, 8'd7, 8'd128};

    add(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b1, 8'd77, 1'b0, 8'd0, 1'b0);
    add_frame(asc, asc_r, 1'b0);
    add_frame(asc, asc_r, 1'b1);
    add_frame(ext, ext_r, 1'b0);
    // Partial frame of 7 pixels, then reset alongside a pixel that must be dropped.
    for (int i = 0; i < 7; i++) begin
      if (i == 5) held = 8'd6;
      add(1'b0, 1'b1, 8'(i + 1), i == 5, held, 1'b0);
    end
    held = '0;
    add(1'b1, 1'b1, 8'd99, 1'b0, held, 1'b0);
    add_frame(asc, asc_r, 1'b0);
    add_frame(asc, asc_r, 1'b0);
    add_frame(desc, desc_r, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst  = tbl[i].r;
      vld4 = tbl[i].v;
      pix4 = tbl[i].p;
      @(negedge clk);
      check("pool_valid", i, 8'(pv4), 8'(tbl[i].ev));
      check("pool_out",   i, out4,    tbl[i].eo);
      check("frame_done", i, 8'(fd4), 8'(tbl[i].ed));
    end
    rst = 1'b0; vld4 = 1'b0;

    // 3x3 frame: only block {1,2,4,5} survives; column 2 and row 2 are dropped.
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      pix3 = 8'(i + 1);
      vld3 = 1'b1;
      @(negedge clk);
      if (pv3) pulses++;
      check("odd_valid", i, 8'(pv3), 8'(i == 4));
      if (i >= 4) check("odd_out", i, out3, 8'd5);
      check("odd_done", i, 8'(fd3), 8'(i == 8));
    end
    vld3 = 1'b0;
    pix3 = 8'd200;
    repeat (2) begin
      @(negedge clk);
      check("odd_idle_valid", 9, 8'(pv3), 8'd0);
      check("odd_idle_done",  9, 8'(fd3), 8'd0);
      check("odd_hold_out",   9, out3,    8'd5);
    end
    check("odd_pulse_count", 9, 8'(pulses), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/maxpool_2x2_stream.md
# maxpool_2x2_stream

Streaming 2×2 max-pooling stage (stride 2) that consumes the clamped 8-bit interior-pixel stream from the 3×3 convolution top level (`pixel_out` / `pixel_out_valid`). It emits one pooled pixel per non-overlapping 2×2 block in raster order. Odd trailing columns and rows are dropped. Storage is one half-row buffer plus a pair register, with no backpressure, which matches the valid-only upstream.

## Interface
- `IN_W`, default 3: input (post-convolution) frame width in pixels, ≥2; equals conv image width − 2.
- `IN_H`, default 3: input frame height in rows, ≥2.
- `DATA_W`, default 8: pixel width, unsigned.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_pixel`  in  DATA_W  input pixel; sampled only when `in_valid`=1.
- `in_valid`  in  1  one pixel per asserted cycle, raster order; gaps allowed.
- `pool_out`  out  DATA_W  pooled maximum; holds its value between pulses.
- `pool_valid`  out  1  single-cycle pulse, one per emitted pooled pixel.
- `frame_done`  out  1  single-cycle pulse after the last pixel of an input frame is accepted.

## Operation
- Counters:
  - `col_cnt` (0..IN_W−1) and `row_cnt` (0..IN_H−1) advance only on `in_valid`.
  - When `col_cnt`=IN_W−1, `col_cnt` wraps to 0 and `row_cnt` increments.
  - When `row_cnt`=IN_H−1 and `col_cnt`=IN_W−1, both wrap to 0 and the next frame begins.
- Active region: pixels with `col_cnt` < 2·⌊IN_W/2⌋ and `row_cnt` < 2·⌊IN_H/2⌋. All other pixels are accepted for counting only and have no effect on data state or outputs.
- Even column (`col_cnt[0]`=0): latch `in_pixel` into `pair_reg`.
- Odd column: `hmax` = max(`pair_reg`, `in_pixel`), unsigned compare.
  - Even row: write `hmax` to `rowbuf[col_cnt>>1]`. The buffer holds ⌊IN_W/2⌋ entries.
  - Odd row: `pool_out` ← max(`rowbuf[col_cnt>>1]`, `hmax`) and `pool_valid` ← 1.
- Ties: equal values give that value; no preference is observable.
- Output count per frame is exactly ⌊IN_W/2⌋·⌊IN_H/2⌋.
- `rowbuf` and `pair_reg` need no reset. They are always written before being read within a frame.

## Timing
- Reset values:
  - `pool_out`=0, `pool_valid`=0, `frame_done`=0.
  - `col_cnt`=0, `row_cnt`=0.
- Latency: `pool_valid` and `pool_out` update on the clock edge following the cycle in which the bottom-right pixel of a 2×2 block is presented with `in_valid`=1. Latency is 1 cycle.
- `pool_valid` is 0 in every cycle that does not complete a block, including every cycle with `in_valid`=0.
- `frame_done` asserts for 1 cycle on the edge after the pixel at (`row`=IN_H−1, `col`=IN_W−1) is accepted. It may coincide with `pool_valid` when both IN_W and IN_H are even.
- Back-to-back frames need no idle cycles. A new frame's first pixel may arrive in the cycle right after the last pixel of the previous frame.
- Reset mid-frame: on the next edge, counters return to 0 and `pool_valid`/`frame_done` drop to 0. The partial frame is discarded, and the next `in_valid` pixel is treated as (0,0).
- `rst` has priority over `in_valid` in the same cycle; that pixel is dropped.
- Throughput: one input pixel per cycle sustained; no stalls.

## Test plan
- Basic 4×4 (IN_W=4, IN_H=4): stream 1..16 contiguously.
  - Required: `pool_valid` pulses carrying 6, 8, 14, 16.
  - Each pulse appears 1 cycle after the pixels with values 6, 8, 14, 16 respectively.
  - `frame_done` coincides with the final pulse.
- Odd dimensions (defaults 3×3): stream 1..9.
  - Required: exactly one pulse, `pool_out`=5.
  - Column 2 and row 2 are discarded.
  - `frame_done` 1 cycle after pixel 9.
- Gapped input, 4×4: same data with `in_valid` low for 1–3 random cycles between pixels.
  - Required: identical output values and order to the contiguous run.
  - No pulse during gaps.
  - `pool_out` is held between pulses.
- Extremes and ties, 4×4: a block of all 255, a block of all 0, and a block {7,7,3,7}.
  - Required outputs 255, 0, 7.
  - Confirms unsigned compare with no sign misinterpretation of 0x80–0xFF.
- Reset mid-frame, 4×4: assert `rst` after pixel 7.
  - Required: next edge `pool_out`=0, `pool_valid`=0.
  - A fresh 1..16 stream then yields 6, 8, 14, 16 with no stale data.
- Back-to-back frames, 4×4: 1..16 immediately followed by 16..1.
  - Required: 6, 8, 14, 16, then 16, 14, 8, 6.
  - `frame_done` pulses exactly twice.
